// File: rtl/inst_mem_loader.sv
// inst_mem_loader
//   Field-reloadable instruction memory for the single-cycle MIPS core.
//   Fetch side: combinational word read from a byte address, returning
//   NOP_WORD while a load is running or when the address is misaligned or
//   out of range.
//   Load side: a byte stream (LSB of each word first) is packed into words
//   and written sequentially from word 0. Each completed word costs one
//   bubble cycle (COMMIT) in which load_ready is low.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-low; clears control state, not memory
//   addr        fetch byte address
//   data        fetched instruction (combinational)
//   addr_err    misaligned or out-of-range fetch address (combinational)
//   load_start  one-cycle pulse that opens a load session (IDLE only)
//   load_valid  load_byte is valid this cycle
//   load_byte   next program byte
//   load_last   marks load_byte as the final byte of the image
//   load_ready  loader accepts a byte this cycle
//   busy        load session active; core must stall
//   load_done   one-cycle pulse when a session completes
//   word_count  words written in the last or current session
module inst_mem_loader #(
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           addr,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  addr_err,
   input  logic                  load_start,
   input  logic                  load_valid,
   input  logic [7:0]            load_byte,
   input  logic                  load_last,
   output logic                  load_ready,
   output logic                  busy,
   output logic                  load_done,
   output logic [ADDR_WIDTH:0]   word_count
);

   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int DEPTH  = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, RECV, COMMIT, DONE} state_t;

   state_t                  state, state_nx;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic [ADDR_WIDTH-1:0]   wptr;
   logic [BCW-1:0]          bcnt;
   logic [DATA_WIDTH-1:0]   buffer;
   logic                    last_f;
   logic                    hs;
   logic                    word_end;
   logic                    mem_full;
   logic [ADDR_WIDTH-1:0]   widx;

   assign hs       = load_valid && load_ready;
   // Word closes on its final byte or early on the image's last byte.
   assign word_end = (bcnt == BCW'(NBYTES - 1)) || load_last;
   assign mem_full = (wptr == ADDR_WIDTH'(DEPTH - 1));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (load_start)      state_nx = RECV;
         RECV:    if (hs && word_end)  state_nx = COMMIT;
         COMMIT:  state_nx = (last_f || mem_full) ? DONE : RECV;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // ---------------- FSM: decoded output ----------------
   always_comb begin
      load_ready = (state == RECV);
   end

   // Session counters, byte packing and registered status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr       <= '0;
         bcnt       <= '0;
         buffer     <= '0;
         last_f     <= 1'b0;
         word_count <= '0;
         busy       <= 1'b0;
         load_done  <= 1'b0;
      end else begin
         load_done <= (state == COMMIT) && (state_nx == DONE);
         case (state)
            IDLE: begin
               if (load_start) begin
                  wptr       <= '0;
                  bcnt       <= '0;
                  buffer     <= '0;
                  last_f     <= 1'b0;
                  word_count <= '0;
                  busy       <= 1'b1;
               end
            end
            RECV: begin
               if (hs) begin
                  for (int i = 0; i < NBYTES; i++) begin
                     if (bcnt == BCW'(i)) buffer[8*i +: 8] <= load_byte;
                  end
                  bcnt   <= bcnt + BCW'(1);
                  last_f <= load_last;
               end
            end
            COMMIT: begin
               // Buffer is cleared here so a short final word has zero upper bytes.
               wptr       <= wptr + ADDR_WIDTH'(1);
               word_count <= word_count + (ADDR_WIDTH+1)'(1);
               bcnt       <= '0;
               buffer     <= '0;
            end
            DONE: begin
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Memory array is deliberately outside the reset domain.
   always_ff @(posedge clk) begin
      if (state == COMMIT) mem[wptr] <= buffer;
   end

   // Fetch path: combinational, independent of the load handshake.
   assign widx     = addr[ADDR_WIDTH+1:2];
   assign addr_err = (addr[1:0] != 2'b00) || (addr[31:ADDR_WIDTH+2] != '0);
   assign data     = (busy || addr_err) ? NOP_WORD : mem[widx];

endmodule

// File: tb/tb_inst_mem_loader.sv
// Testbench for inst_mem_loader: a default-size instance (256 words) and a
// 4-word instance for the memory-full case. Fetch expectations and
// expected session word counts are queued by the stimulus and consumed by
// a negedge monitor.
module tb_inst_mem_loader;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr;
   logic        load_start, load_valid, load_last;
   logic [7:0]  load_byte;
   logic        s_load_start, s_load_valid;

   logic [31:0] data,   s_data;
   logic        addr_err, s_addr_err;
   logic        load_ready, s_load_ready;
   logic        busy, s_busy;
   logic        load_done, s_load_done;
   logic [8:0]  word_count;
   logic [2:0]  s_word_count;

   always #5 clk = ~clk;

   inst_mem_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NOP_WORD(NOP)) u_dut (
      .clk(clk), .reset(rst_n), .addr(addr), .data(data), .addr_err(addr_err),
      .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
      .load_last(load_last), .load_ready(load_ready), .busy(busy),
      .load_done(load_done), .word_count(word_count));

   inst_mem_loader #(.ADDR_WIDTH(2), .DATA_WIDTH(32), .NOP_WORD(NOP)) u_small (
      .clk(clk), .reset(rst_n), .addr(addr), .data(s_data), .addr_err(s_addr_err),
      .load_start(s_load_start), .load_valid(s_load_valid), .load_byte(load_byte),
      .load_last(load_last), .load_ready(s_load_ready), .busy(s_busy),
      .load_done(s_load_done), .word_count(s_word_count));

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      bit          sel;
      logic [31:0] a;
      logic [31:0] exp_data;
      logic        exp_err;
   } fexp_t;

   fexp_t      fq[$];
   int         dq[$];
   int         sdq[$];
   logic       fstrobe = 1'b0;
   fexp_t      fe;
   logic [7:0] img[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pat(input int i);
      logic [7:0] b;
      b = 8'(i);
      return {8'hC3, ~b, b ^ 8'h5A, b};
   endfunction

   // Monitor: compares queued expectations against what the DUTs present.
   always @(negedge clk) begin
      if (fstrobe) begin
         if (fq.size() == 0) check("fetch_queue_empty", 32'd1, 32'd0);
         else begin
            fe = fq.pop_front();
            if (fe.sel) begin
               check($sformatf("s_fetch_data@%h", fe.a), s_data, fe.exp_data);
               check($sformatf("s_fetch_err@%h", fe.a), 32'(s_addr_err), 32'(fe.exp_err));
            end else begin
               check($sformatf("fetch_data@%h", fe.a), data, fe.exp_data);
               check($sformatf("fetch_err@%h", fe.a), 32'(addr_err), 32'(fe.exp_err));
            end
         end
      end
      if (load_done) begin
         if (dq.size() == 0) check("unexpected_load_done", 32'd1, 32'd0);
         else check("word_count_at_done", 32'(word_count), 32'(dq.pop_front()));
      end
      if (s_load_done) begin
         if (sdq.size() == 0) check("s_unexpected_load_done", 32'd1, 32'd0);
         else check("s_word_count_at_done", 32'(s_word_count), 32'(sdq.pop_front()));
      end
   end

   task automatic fetch(input bit sel, input logic [31:0] a, input logic [31:0] ed, input logic ee);
      fexp_t e;
      @(posedge clk); #1;
      addr = a;
      e.sel = sel; e.a = a; e.exp_data = ed; e.exp_err = ee;
      fq.push_back(e);
      fstrobe = 1'b1;
      @(negedge clk); #1;
      fstrobe = 1'b0;
   endtask

   task automatic drive_start(input bit sel);
      @(posedge clk); #1;
      if (sel) s_load_start = 1'b1; else load_start = 1'b1;
      @(posedge clk); #1;
      s_load_start = 1'b0; load_start = 1'b0;
      @(negedge clk);
      check("busy_after_start", 32'(sel ? s_busy : busy), 32'd1);
   endtask

   task automatic send_byte(input bit sel, input logic [7:0] b, input bit last,
                            input int gap_pct, input bit ends_word);
      int t;
      @(posedge clk); #1;
      t = 0;
      while (int'($urandom_range(99)) < gap_pct && t < 20) begin
         @(posedge clk); #1; t++;
      end
      load_byte = b; load_last = last;
      if (sel) s_load_valid = 1'b1; else load_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!(sel ? s_load_ready : load_ready) && t < 50) begin
         @(negedge clk); t++;
      end
      if (t >= 50) check("handshake_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      load_valid = 1'b0; s_load_valid = 1'b0; load_last = 1'b0;
      if (ends_word) begin
         @(negedge clk);
         check("ready_low_in_commit", 32'(sel ? s_load_ready : load_ready), 32'd0);
      end
   endtask

   task automatic load_img(input bit sel, input bit use_last, input int gap_pct, input int start_at);
      bit lst;
      for (int k = 0; k < img.size(); k++) begin
         if (k == start_at) begin
            @(posedge clk); #1; load_start = 1'b1;
            @(posedge clk); #1; load_start = 1'b0;
         end
         lst = use_last && (k == img.size() - 1);
         send_byte(sel, img[k], lst, gap_pct, ((k % 4) == 3) || lst);
      end
   endtask

   task automatic wait_idle(input bit sel);
      int t;
      t = 0;
      @(negedge clk);
      while ((sel ? s_busy : busy) && t < 20) begin
         @(negedge clk); t++;
      end
      check("busy_clears", 32'(sel ? s_busy : busy), 32'd0);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; addr = '0; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
      load_byte = '0; s_load_start = 1'b0; s_load_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(load_ready), 32'd0);
      check("rst_done", 32'(load_done), 32'd0);
      check("rst_word_count", 32'(word_count), 32'd0);
      check("rst_s_ready", 32'(s_load_ready), 32'd0);
      rst_n = 1'b1;

      // Fill all 256 words; session ends on memory full without load_last.
      img.delete();
      for (int i = 0; i < 256; i++) begin
         img.push_back(pat(i)[7:0]);   img.push_back(pat(i)[15:8]);
         img.push_back(pat(i)[23:16]); img.push_back(pat(i)[31:24]);
      end
      dq.push_back(256);
      drive_start(1'b0);
      load_img(1'b0, 1'b0, 0, -1);
      wait_idle(1'b0);
      fetch(1'b0, 32'h0000_03FC, pat(255), 1'b0);
      fetch(1'b0, 32'h0000_0000, pat(0), 1'b0);
      fetch(1'b0, 32'h0000_0200, pat(128), 1'b0);
      fetch(1'b0, 32'h0000_0402, NOP, 1'b1);
      fetch(1'b0, 32'h0000_0400, NOP, 1'b1);
      fetch(1'b0, 32'h0000_0101, NOP, 1'b1);

      // Start pulse and fetch in the same cycle still returns memory data.
      @(posedge clk); #1;
      load_start = 1'b1; addr = 32'h0000_03FC;
      fe.sel = 1'b0; fe.a = addr; fe.exp_data = pat(255); fe.exp_err = 1'b0;
      fq.push_back(fe);
      fstrobe = 1'b1;
      @(negedge clk); #1;
      fstrobe = 1'b0;
      @(posedge clk); #1;
      load_start = 1'b0;
      @(negedge clk);
      check("busy_after_start", 32'(busy), 32'd1);
      fetch(1'b0, 32'h0000_03FC, NOP, 1'b0);
      fetch(1'b0, 32'h0000_0402, NOP, 1'b1);
      img = '{8'hAF, 8'h3C, 8'h08, 8'h25, 8'h27, 8'h40, 8'h00, 8'h00};
      dq.push_back(2);
      load_img(1'b0, 1'b1, 0, -1);
      wait_idle(1'b0);
      fetch(1'b0, 32'h0000_0000, 32'h2508_3CAF, 1'b0);
      fetch(1'b0, 32'h0000_0004, 32'h0000_4027, 1'b0);
      fetch(1'b0, 32'h0000_0008, pat(2), 1'b0);

      // Short final word.
      img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA};
      dq.push_back(2);
      drive_start(1'b0);
      load_img(1'b0, 1'b1, 0, -1);
      wait_idle(1'b0);
      fetch(1'b0, 32'h0000_0000, 32'h0403_0201, 1'b0);
      fetch(1'b0, 32'h0000_0004, 32'h0000_00AA, 1'b0);

      // Sparse valid plus a stray load_start mid-session.
      img = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h55, 8'h66, 8'h77, 8'h88, 8'h9A, 8'hBC, 8'hDE};
      dq.push_back(3);
      drive_start(1'b0);
      load_img(1'b0, 1'b1, 70, 3);
      wait_idle(1'b0);
      fetch(1'b0, 32'h0000_0000, 32'h4030_2010, 1'b0);
      fetch(1'b0, 32'h0000_0004, 32'h8877_6655, 1'b0);
      fetch(1'b0, 32'h0000_0008, 32'h00DE_BC9A, 1'b0);
      fetch(1'b0, 32'h0000_000C, pat(3), 1'b0);

      // Reset mid-load after 6 bytes.
      img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      drive_start(1'b0);
      load_img(1'b0, 1'b0, 0, -1);
      @(posedge clk); #1; rst_n = 1'b0;
      @(negedge clk);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_word_count", 32'(word_count), 32'd0);
      check("midrst_ready", 32'(load_ready), 32'd0);
      @(posedge clk); #1; rst_n = 1'b1;
      fetch(1'b0, 32'h0000_0000, 32'h4433_2211, 1'b0);
      fetch(1'b0, 32'h0000_0004, 32'h8877_6655, 1'b0);
      img = '{8'hE1, 8'hE2, 8'hE3};
      dq.push_back(1);
      drive_start(1'b0);
      load_img(1'b0, 1'b1, 0, -1);
      wait_idle(1'b0);
      fetch(1'b0, 32'h0000_0000, 32'h00E3_E2E1, 1'b0);
      fetch(1'b0, 32'h0000_0004, 32'h8877_6655, 1'b0);

      // 4-word memory: 16 bytes fill it, further bytes are refused.
      img.delete();
      for (int i = 1; i <= 16; i++) img.push_back(8'(i));
      sdq.push_back(4);
      drive_start(1'b1);
      load_img(1'b1, 1'b0, 0, -1);
      @(posedge clk); #1;
      s_load_valid = 1'b1; load_byte = 8'hEE;
      for (int i = 17; i <= 20; i++) begin
         @(negedge clk);
         check($sformatf("s_ready_byte%0d", i), 32'(s_load_ready), 32'd0);
         @(posedge clk); #1;
      end
      s_load_valid = 1'b0;
      wait_idle(1'b1);
      check("s_word_count_final", 32'(s_word_count), 32'd4);
      fetch(1'b1, 32'h0000_0000, 32'h0403_0201, 1'b0);
      fetch(1'b1, 32'h0000_0004, 32'h0807_0605, 1'b0);
      fetch(1'b1, 32'h0000_0008, 32'h0C0B_0A09, 1'b0);
      fetch(1'b1, 32'h0000_000C, 32'h100F_0E0D, 1'b0);
      fetch(1'b1, 32'h0000_0010, NOP, 1'b1);

      repeat (4) @(posedge clk);
      check("pending_done", 32'(dq.size()), 32'd0);
      check("s_pending_done", 32'(sdq.size()), 32'd0);
      check("pending_fetch", 32'(fq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
